// File: rtl/cell_sweep_pkg.sv
// Shared types and reference truth tables for the cell sweep controller.
package cell_sweep_pkg;

   // Sweep sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StApply,
      StSettle,
      StSample,
      StDone
   } state_e;

   // Reference truth tables for 3-input cells, bit k = output for vector k
   localparam logic [7:0] NOR3_TT  = 8'h01;
   localparam logic [7:0] NAND3_TT = 8'h7F;
   localparam logic [7:0] AND3_TT  = 8'h80;
   localparam logic [7:0] OR3_TT   = 8'hFE;

endpackage

// File: rtl/cell_sweep_timer.sv
// Settle-delay down-counter: load a count, decrement while enabled, flag the last cycle.
module cell_sweep_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       expired
);

   logic [7:0] cnt;

   // Count register: load takes priority, decrement stops at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Loaded with N, the holder sees expired on its N-th cycle in the wait state
   assign expired = (cnt <= 8'd1);

endmodule

// File: rtl/cell_sweep_ctrl.sv
// Exhaustive truth-table sweep of a combinational cell: drives every input vector,
// waits a settle time, samples the cell output and tallies mismatches.
// Optional feature: define CELL_SWEEP_LOG_EN to record the observed truth table in obs_tt.
module cell_sweep_ctrl
   import cell_sweep_pkg::*;
#(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expect_tt,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_zn,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic [N_IN-1:0]      first_fail,
   output logic [2**N_IN-1:0]   obs_tt
);

   localparam int unsigned     NVec       = 2**N_IN;
   localparam logic [N_IN-1:0] LastVec    = N_IN'(NVec - 1);
   localparam logic [7:0]      SettleLoad = 8'(SETTLE_CYCLES);

   state_e            state;
   logic [N_IN-1:0]   vec;
   logic [NVec-1:0]   exp_q;
   logic              mismatch;
   logic              timer_expired;
   logic              start_ok;

   assign mismatch = (dut_zn != exp_q[vec]);
   assign start_ok = ((state == StIdle) || (state == StDone)) && start;

   // The applied vector is the sweep index itself, so it holds through SAMPLE and in DONE
   assign dut_in = vec;

   cell_sweep_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == StApply),
      .load_val (SettleLoad),
      .dec      (state == StSettle),
      .expired  (timer_expired)
   );

   // Sequencer with registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         vec        <= '0;
         exp_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         first_fail <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state      <= StApply;
                  vec        <= '0;
                  exp_q      <= expect_tt;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  first_fail <= '0;
               end
            end
            StApply: begin
               state <= (SETTLE_CYCLES == 0) ? StSample : StSettle;
            end
            StSettle: begin
               if (timer_expired) begin
                  state <= StSample;
               end
            end
            StSample: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + (N_IN + 1)'(1);
                  if (err_cnt == '0) begin
                     first_fail <= vec;
                  end
               end
               if (vec == LastVec) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == '0) && !mismatch;
               end else begin
                  state <= StApply;
                  vec   <= vec + N_IN'(1);
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

`ifdef CELL_SWEEP_LOG_EN
   logic [NVec-1:0] obs_q;

   // Observed truth table, one bit written per sampled vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obs_q <= '0;
      end else if (start_ok) begin
         obs_q <= '0;
      end else if (state == StSample) begin
         obs_q[vec] <= dut_zn;
      end
   end

   assign obs_tt = obs_q;
`else
   assign obs_tt = '0;
`endif

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// Randomised and directed bench for cell_sweep_ctrl: two instances (settle 2 and settle 0)
// share stimulus and are checked every cycle against a phase-arithmetic model.
module tb_cell_sweep_ctrl;
   import cell_sweep_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [7:0]      expect_tt = 8'h00;
   logic [7:0]      cell_tt = 8'h00;

   logic [1:0][2:0] din;
   logic [1:0]      zn;
   logic [1:0]      busy, done, pass;
   logic [1:0][3:0] err;
   logic [1:0][2:0] ff;
   logic [1:0][7:0] obs;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model state per instance: cycles since accepted start, captured tables
   int         mm[2];
   bit         started[2];
   logic [7:0] mexp[2];
   logic [7:0] mobs[2];

   int         seq1[32];

   always #5 clk = ~clk;

   assign zn[0] = cell_tt[din[0]];
   assign zn[1] = cell_tt[din[1]];

   cell_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
      .dut_in(din[0]), .dut_zn(zn[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_cnt(err[0]), .first_fail(ff[0]), .obs_tt(obs[0])
   );

   cell_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
      .dut_in(din[1]), .dut_zn(zn[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_cnt(err[1]), .first_fail(ff[1]), .obs_tt(obs[1])
   );

   function automatic int per_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   task automatic chk(input string name, input int act, input int want);
      n_assert++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Behavioural model: a sweep is 8 vectors of per cycles each, done after 8*per cycles
   initial begin
      for (int i = 0; i < 2; i++) begin
         mm[i] = 0; started[i] = 1'b0; mexp[i] = 8'h00; mobs[i] = 8'h00;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               mm[i] = 0; started[i] = 1'b0; mexp[i] = 8'h00; mobs[i] = 8'h00;
            end else if ((!started[i] || mm[i] >= 8 * per_of(i)) && start) begin
               started[i] = 1'b1; mm[i] = 0; mexp[i] = expect_tt; mobs[i] = 8'h00;
            end else if (started[i] && mm[i] < 8 * per_of(i)) begin
               if (mm[i] % per_of(i) == per_of(i) - 1)
                  mobs[i][mm[i] / per_of(i)] = cell_tt[mm[i] / per_of(i)];
               mm[i]++;
            end
         end
      end
   end

   // Per-cycle compare of every output of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               int comp, errs, ffv, dv;
               logic e_busy, e_done, e_pass;
               logic [7:0] e_obs;
               logic [20:0] act, want;
               if (!started[i]) begin
                  comp = 0; dv = 0; e_busy = 0; e_done = 0;
               end else begin
                  comp = mm[i] / per_of(i);
                  if (comp > 8) comp = 8;
                  dv = (comp > 7) ? 7 : comp;
                  e_busy = (mm[i] < 8 * per_of(i));
                  e_done = !e_busy;
               end
               errs = 0; ffv = 0;
               for (int v = 7; v >= 0; v--) begin
                  if (v < comp && mobs[i][v] != mexp[i][v]) begin
                     errs++; ffv = v;
                  end
               end
               e_pass = e_done && (errs == 0);
`ifdef CELL_SWEEP_LOG_EN
               e_obs = mobs[i];
`else
               e_obs = 8'h00;
`endif
               want = {e_busy, e_done, e_pass, 4'(errs), 3'(ffv), 3'(dv), e_obs};
               act  = {busy[i], done[i], pass[i], err[i], ff[i], din[i], obs[i]};
               n_assert++;
               if (act !== want) begin
                  n_fail++;
                  $display("FAIL cycle_dut%0d t=%0t got b/d/p/err/ff/in/obs=%b/%b/%b/%0d/%0d/%0d/%h expected %b/%b/%b/%0d/%0d/%0d/%h",
                           i, $time, busy[i], done[i], pass[i], err[i], ff[i], din[i], obs[i],
                           e_busy, e_done, e_pass, errs, ffv, dv, e_obs);
               end
            end
         end
      end
   end

   // One full sweep on both instances; latency counted from the cycle start is raised
   task automatic run_sweep(input logic [7:0] e, input logic [7:0] c,
                            output int lat0, output int lat1);
      expect_tt = e;
      cell_tt   = c;
      @(posedge clk); #1;
      start = 1'b1;
      lat0 = -1; lat1 = -1;
      for (int cyc = 1; cyc <= 60 && lat0 < 0; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (cyc < 32) seq1[cyc] = int'(din[1]);
         if (lat1 < 0 && done[1]) lat1 = cyc;
         if (lat0 < 0 && done[0]) lat0 = cyc;
      end
   endtask

   task automatic wait_vec0(input int v, input string name);
      int k;
      k = 0;
      while (int'(din[0]) != v && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, int'(din[0]), v);
   endtask

   initial begin
      int l0, l1;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err",  int'(err), 0);
      chk("reset_din",  int'(din), 0);
      #19 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Healthy NOR3
      run_sweep(NOR3_TT, NOR3_TT, l0, l1);
      chk("nor3_lat_s2", l0, 33);
      chk("nor3_lat_s0", l1, 17);
      chk("nor3_pass", int'(pass[0]), 1);
      chk("nor3_err", int'(err[0]), 0);
      chk("nor3_ff", int'(ff[0]), 0);
`ifdef CELL_SWEEP_LOG_EN
      chk("nor3_obs", int'(obs[0]), 8'h01);
`else
      chk("nor3_obs", int'(obs[0]), 0);
`endif

      // Output stuck at 0
      run_sweep(NOR3_TT, 8'h00, l0, l1);
      chk("stuck0_err", int'(err[0]), 1);
      chk("stuck0_ff", int'(ff[0]), 0);
      chk("stuck0_pass", int'(pass[0]), 0);

      // Inverted output: every vector wrong
      run_sweep(NOR3_TT, ~NOR3_TT, l0, l1);
      chk("inv_err", int'(err[0]), 8);
      chk("inv_err_s0", int'(err[1]), 8);
      chk("inv_ff", int'(ff[0]), 0);
`ifdef CELL_SWEEP_LOG_EN
      chk("inv_obs", int'(obs[0]), 8'hFE);
`else
      chk("inv_obs", int'(obs[0]), 0);
`endif

      // Two faults at vectors 3 and 5
      run_sweep(NOR3_TT, NOR3_TT ^ 8'h28, l0, l1);
      chk("two_err", int'(err[0]), 2);
      chk("two_ff", int'(ff[0]), 3);

      // NAND3, settle 0: each vector held two cycles
      run_sweep(NAND3_TT, NAND3_TT, l0, l1);
      chk("nand3_lat_s0", l1, 17);
      chk("nand3_pass_s0", int'(pass[1]), 1);
      for (int k = 1; k <= 16; k++) chk("nand3_din_seq", seq1[k], (k - 1) / 2);

      // Start while busy is ignored, then reset aborts the sweep
      expect_tt = NOR3_TT; cell_tt = NOR3_TT;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_vec0(3, "wait_vec3");
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_start_ignored", int'(din[0]), 3);
      wait_vec0(5, "wait_vec5");
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_pass", int'(pass), 0);
      chk("midrst_err", int'(err), 0);
      chk("midrst_ff", int'(ff), 0);
      chk("midrst_din", int'(din), 0);
      chk("midrst_obs", int'(obs), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("post_rst_idle", int'({busy, done}), 0);
      run_sweep(NOR3_TT, NOR3_TT, l0, l1);
      chk("post_rst_lat", l0, 33);
      chk("post_rst_pass", int'(pass[0]), 1);

      // Random phase: random starts (some while busy), random tables
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 9) == 0);
         expect_tt = 8'($urandom);
         if ($urandom_range(0, 15) == 0) cell_tt = 8'($urandom);
      end
      start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
